// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants and helpers for the VRAM write path
package gpu_pkg;

    localparam int VRAM_ADDR_W = 15;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_LAST   = 18448;
    localparam int ENTRY_W     = VRAM_ADDR_W + VRAM_DATA_W;

    typedef enum logic [1:0] {
        SEL_ADDR_LO = 2'd0,
        SEL_ADDR_HI = 2'd1,
        SEL_DATA    = 2'd2,
        SEL_STATUS  = 2'd3
    } reg_sel_e;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    // Next pointer value: anything at or beyond the last valid byte wraps to 0,
    // which also covers a pointer that was loaded out of range.
    function automatic logic [VRAM_ADDR_W-1:0] ptr_next(input logic [VRAM_ADDR_W-1:0] p,
                                                        input int last);
        if (int'({1'b0, p}) >= last) begin
            return '0;
        end
        return p + VRAM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty/count status
module sync_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Push is refused when full and pop when empty; both may proceed together.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all queued entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - CPU register port that queues byte writes into VRAM
module vram_writer
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_LAST   = VRAM_LAST
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             reg_sel,
    input  logic                   reg_we,
    input  logic                   reg_re,
    input  logic [7:0]             reg_wdata,
    output logic [7:0]             reg_rdata,
    input  logic                   mem_ready,
    output logic                   w_en,
    output logic [VRAM_ADDR_W-1:0] w_addr,
    output logic [VRAM_DATA_W-1:0] w_data,
    output logic                   busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [VRAM_ADDR_W-1:0] ptr_q, ptr_d;
    logic                   autoinc_q, autoinc_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   w_en_q, w_en_d;
    logic [VRAM_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [VRAM_DATA_W-1:0] w_data_q, w_data_d;

    logic                   push, pop, ovf_event, status_rd;
    logic [ENTRY_W-1:0]     push_entry, head_entry;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register writes, queue push, overflow tracking, read data and drain select.
    always_comb begin
        ptr_d      = ptr_q;
        autoinc_d  = autoinc_q;
        push       = 1'b0;
        ovf_event  = 1'b0;
        push_entry = {ptr_q, reg_wdata};
        rdata_d    = rdata_q;

        if (reg_we) begin
            case (reg_sel)
                SEL_ADDR_LO: ptr_d[7:0] = reg_wdata;
                SEL_ADDR_HI: begin
                    ptr_d[VRAM_ADDR_W-1:8] = reg_wdata[6:0];
                    autoinc_d              = reg_wdata[7];
                end
                SEL_DATA: begin
                    // Fullness is judged before any same-cycle pop frees a slot.
                    if (fifo_full) begin
                        ovf_event = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (autoinc_q) begin
                            ptr_d = ptr_next(ptr_q, MEM_LAST);
                        end
                    end
                end
                default: ;
            endcase
        end

        status_rd = reg_re && (reg_sel == SEL_STATUS);
        // A new overflow on the clearing read edge must survive the clear.
        ovf_d = (ovf_q && !status_rd) || ovf_event;

        if (reg_re) begin
            case (reg_sel)
                SEL_ADDR_LO: rdata_d = ptr_q[7:0];
                SEL_ADDR_HI: rdata_d = {autoinc_q, ptr_q[VRAM_ADDR_W-1:8]};
                SEL_DATA:    rdata_d = 8'h00;
                default: begin
                    rdata_d             = 8'h00;
                    rdata_d[STAT_OVF]   = ovf_q;
                    rdata_d[STAT_FULL]  = fifo_full;
                    rdata_d[STAT_EMPTY] = fifo_empty;
                end
            endcase
        end

        pop      = mem_ready && (fifo_count != '0);
        w_en_d   = pop;
        w_addr_d = pop ? head_entry[ENTRY_W-1:VRAM_DATA_W] : w_addr_q;
        w_data_d = pop ? head_entry[VRAM_DATA_W-1:0] : w_data_q;
    end

    // Architectural registers and the registered VRAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            autoinc_q <= 1'b0;
            ovf_q     <= 1'b0;
            rdata_q   <= '0;
            w_en_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            autoinc_q <= autoinc_d;
            ovf_q     <= ovf_d;
            rdata_q   <= rdata_d;
            w_en_q    <= w_en_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign w_en      = w_en_q;
    assign w_addr    = w_addr_q;
    assign w_data    = w_data_q;
    assign busy      = fifo_full;

endmodule

// File: doc/vram_writer.md
VRAM_WRITER -- requirements
Module: vram_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the write-queue depth (power of two, 2..16).
REQ-002 Parameter MEM_LAST, default 18448, SHALL set the last valid VRAM byte address.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 reg_sel  input  2  SHALL select the register: 0 addr-low, 1 addr-high, 2 data, 3 status.
REQ-006 reg_we  input  1  SHALL be a one-cycle CPU write strobe.
REQ-007 reg_re  input  1  SHALL be a one-cycle CPU read strobe.
REQ-008 reg_wdata  input  8  SHALL carry the CPU write data.
REQ-009 reg_rdata  output  8  SHALL carry the registered CPU read data.
REQ-010 mem_ready  input  1  SHALL indicate that the VRAM write slot is free this cycle.
REQ-011 w_en  output  1  SHALL be the VRAM write enable, one-cycle pulse per byte.
REQ-012 w_addr  output  15  SHALL carry the VRAM write address, valid while w_en=1.
REQ-013 w_data  output  8  SHALL carry the VRAM write data, valid while w_en=1.
REQ-014 busy  output  1  SHALL equal the FIFO-full flag.

Function
REQ-015 A 15-bit address pointer SHALL be maintained: addr-low write loads [7:0]; addr-high write loads [14:8] from reg_wdata[6:0] and the auto-increment flag from reg_wdata[7].
REQ-016 A data-register write with the FIFO not full SHALL push {pointer, reg_wdata} and, if auto-increment=1, advance the pointer by 1.
REQ-017 Pointer increment from MEM_LAST SHALL wrap to 0; a pointer loaded above MEM_LAST SHALL also wrap to 0 on its next increment.
REQ-018 A data-register write while full (count==FIFO_DEPTH) SHALL be dropped, leave the pointer unchanged, and set a sticky overflow flag, even if a pop occurs in the same cycle.
REQ-019 Push and pop in the same cycle SHALL both take effect with the count unchanged.
REQ-020 When the FIFO is non-empty and mem_ready=1 at an edge, that edge SHALL register w_en=1 with the head entry on w_addr/w_data and pop it; otherwise w_en SHALL be registered 0.
REQ-021 Latency SHALL be one cycle: a data write accepted at edge N, with an empty FIFO and mem_ready held high, SHALL produce w_en=1 during the cycle after edge N+1.
REQ-022 With mem_ready held high, the block SHALL sustain one VRAM write per cycle, in FIFO order.
REQ-023 Queued entries SHALL be unaffected by later pointer loads.
REQ-024 reg_rdata SHALL be registered on reg_re: sel0 pointer[7:0]; sel1 {autoinc, pointer[14:8]}; sel2 0x00; sel3 {5'b0, overflow, full, empty}.
REQ-025 A status read SHALL return the current overflow value and clear it on the same edge; an overflow event on that same edge SHALL win and leave the flag set.
REQ-026 reg_we and reg_re asserted together SHALL both be serviced.
REQ-027 No state machine beyond the FIFO count is required; w_en SHALL never assert while the FIFO is empty.

Reset
REQ-028 Reset SHALL immediately clear: pointer 0, auto-increment 0, FIFO empty, overflow 0, w_en 0, w_addr 0, w_data 0, reg_rdata 0, busy 0.
REQ-029 Reset mid-drain SHALL discard all queued entries; no w_en pulse SHALL follow reset deassertion until a new push occurs.

Structure
REQ-030 Shared package gpu_pkg SHALL hold the register-select constants, the status bit indices, VRAM_ADDR_W=15 and VRAM_LAST=18448.
REQ-031 The queue SHALL be a sub-module sync_fifo, parameterised by width (23) and depth, with full/empty/count outputs.

Verification
REQ-032 Write addr-low 0x34, addr-high 0x92, data 0xAA, data 0xBB with mem_ready=1 -> w_en pulses at 0x1234=0xAA then 0x1235=0xBB, on consecutive cycles.
REQ-033 Load pointer 18448 with autoinc=1, then write data 0x01, 0x02 -> VRAM writes land at 18448 and 0.
REQ-034 mem_ready=0, then write 5 data bytes -> 4 queued, busy=1, status read returns 0x06 then 0x02; set mem_ready=1 -> exactly 4 w_en pulses.
REQ-035 Queue full, mem_ready=1, data write on the same cycle as a pop -> write dropped, overflow=1, count drops to 3.
REQ-036 Queue 3 entries with mem_ready=0, assert reset mid-cycle asynchronously -> outputs 0 immediately; mem_ready=1 after release -> no w_en.
REQ-037 Autoinc=0 and three data writes 0x10/0x20/0x30 at 0x0100 -> three VRAM writes to 0x0100 in order; pointer readback 0x00/0x01.
